// File: rtl/nn_host_sequencer.sv
// Host-side sequencer for the fixed-point network core: loads input samples,
// runs the fill/req four-phase handshakes, then streams out thresholded results.
module nn_host_sequencer #(
   parameter int N_IN    = 2,
   parameter int N_OUT   = 1,
   parameter int DW      = 8,
   parameter int AW_IN   = 1,
   parameter int AW_OUT  = 1,
   parameter int THRESH  = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   output logic              in_trig_w,
   output logic [AW_IN-1:0]  in_abus_w,
   output logic [DW-1:0]     in_dbus_w,
   output logic              fill,
   input  logic              ack_fill,
   output logic              req,
   input  logic              ack_network,
   output logic              out_trig_r,
   output logic [AW_OUT-1:0] out_abus_r,
   input  logic [DW-1:0]     out_dbus_r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic              out_class,
   output logic              out_last,
   output logic              busy,
   output logic              err
);

   localparam int ICW = $clog2(N_IN) + 1;
   localparam int OCW = $clog2(N_OUT) + 1;
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [ICW-1:0]        ILAST    = ICW'(N_IN - 1);
   localparam logic [OCW-1:0]        OLAST    = OCW'(N_OUT - 1);
   localparam logic [WDW-1:0]        WD_MAX   = WDW'(TIMEOUT);
   localparam logic signed [DW-1:0]  THRESH_S = DW'(THRESH);

   typedef enum logic [2:0] {
      S_LOAD, S_FILL, S_FILL_REL, S_RUN, S_RUN_REL, S_READ, S_RWAIT, S_EMIT
   } state_t;

   state_t         state;
   logic [ICW-1:0] icnt;
   logic [OCW-1:0] ocnt;
   logic [OCW-1:0] ocnt_nxt;
   logic [WDW-1:0] wdog;
   logic           accept;
   logic           in_hs;
   logic           wd_hit;

   // Input side is combinational from the stream so a sample lands in memory
   // on the same cycle it is accepted.
   assign in_ready  = (state == S_LOAD);
   assign busy      = (state != S_LOAD);
   assign accept    = in_valid & in_ready;
   assign in_trig_w = accept;
   assign in_abus_w = AW_IN'(icnt);
   assign in_dbus_w = accept ? in_data : '0;

   assign ocnt_nxt = ocnt + 1'b1;
   assign in_hs    = (state == S_FILL) || (state == S_FILL_REL) ||
                     (state == S_RUN)  || (state == S_RUN_REL);
   assign wd_hit   = (wdog == WD_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_LOAD;
         icnt       <= '0;
         ocnt       <= '0;
         wdog       <= '0;
         fill       <= 1'b0;
         req        <= 1'b0;
         out_trig_r <= 1'b0;
         out_abus_r <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_class  <= 1'b0;
         out_last   <= 1'b0;
         err        <= 1'b0;
      end else if (in_hs && wd_hit) begin
         // A core that stops acknowledging abandons the inference, not the host.
         err   <= 1'b1;
         fill  <= 1'b0;
         req   <= 1'b0;
         state <= S_LOAD;
         icnt  <= '0;
         ocnt  <= '0;
         wdog  <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (accept) begin
                  if (icnt == ILAST) begin
                     icnt  <= '0;
                     fill  <= 1'b1;
                     state <= S_FILL;
                  end else begin
                     icnt <= icnt + 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (ack_fill) begin
                  fill  <= 1'b0;
                  wdog  <= '0;
                  state <= S_FILL_REL;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_FILL_REL: begin
               if (!ack_fill) begin
                  req   <= 1'b1;
                  wdog  <= '0;
                  state <= S_RUN;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_RUN: begin
               if (ack_network) begin
                  req   <= 1'b0;
                  wdog  <= '0;
                  state <= S_RUN_REL;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_RUN_REL: begin
               if (!ack_network) begin
                  ocnt       <= '0;
                  out_abus_r <= '0;
                  out_trig_r <= 1'b1;
                  wdog       <= '0;
                  state      <= S_READ;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            S_READ: begin
               out_trig_r <= 1'b0;
               state      <= S_RWAIT;
            end
            S_RWAIT: begin
               // Memory drives read data on the negedge inside READ, so it is settled here.
               out_data  <= out_dbus_r;
               out_class <= ($signed(out_dbus_r) >= THRESH_S);
               out_last  <= (ocnt == OLAST);
               out_valid <= 1'b1;
               state     <= S_EMIT;
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (ocnt == OLAST) begin
                     ocnt  <= '0;
                     state <= S_LOAD;
                  end else begin
                     ocnt       <= ocnt_nxt;
                     out_abus_r <= AW_OUT'(ocnt_nxt);
                     out_trig_r <= 1'b1;
                     state      <= S_READ;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule
